// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ALU front-end sequencer.
//   - default operand and selector widths
//   - state codes driven out on state_o
//   - ALU opcodes; the sequencer passes them through without checking them
package ula_pkg;

  localparam int ULA_WIDTH = 4;
  localparam int ULA_SEL_W = 3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;

endpackage

// File: rtl/ula_operand_seq_edge_pulse.sv
// edge_pulse: rising-edge detector built on a one-flop history of the input.
//   clk    in   clock
//   rst    in   synchronous active-high reset; clears the history flop
//   sig    in   level input, already synchronised to clk
//   pulse  out  high for the one cycle in which sig is 1 and was 0 on the previous edge
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  // The pulse is combinational from the live level, so a press takes effect
  // on the same edge at which the button is first seen high.
  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/ula_operand_seq.sv
// ula_operand_seq: collects A, B and the opcode from shared switches on
// successive enter presses, holds them on the ALU inputs, then captures the
// ALU result and carry once the result has settled.
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   data_in   in   operand from the switches
//   op_in     in   opcode from the switches
//   enter     in   button level; each rising edge counts as one press
//   clear     in   soft clear, same effect as rst, wins over a press
//   alu_a     out  operand A to the ALU
//   alu_b     out  operand B to the ALU
//   alu_sel   out  opcode to the ALU
//   alu_s     in   ALU result
//   alu_cout  in   ALU carry/borrow
//   result    out  captured ALU result
//   carry     out  captured ALU carry
//   done      out  captured result is valid
//   state_o   out  current state code
//
// state  | meaning
// S_A    | waiting for a press to load operand A
// S_B    | waiting for a press to load operand B
// S_OP   | waiting for a press to load the opcode
// S_EXEC | counting settle cycles, then capturing the ALU outputs
// S_SHOW | result displayed; a press starts the next operation
module ula_operand_seq
  import ula_pkg::*;
#(
  parameter int WIDTH     = ULA_WIDTH,
  parameter int SEL_W     = ULA_SEL_W,
  parameter int EXEC_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] op_in,
  input  logic             enter,
  input  logic             clear,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH:0]   alu_s,
  input  logic             alu_cout,
  output logic [WIDTH:0]   result,
  output logic             carry,
  output logic             done,
  output logic [2:0]       state_o
);

  localparam logic [3:0] EXEC_WAIT_C = 4'(EXEC_WAIT);

  state_t     state, state_nx;
  logic       press;
  logic       srst;
  logic [3:0] cnt;
  logic       ld_a, ld_b, ld_sel, cnt_dec, capture, done_clr;

  // Soft clear behaves exactly like reset, including the press history.
  assign srst = rst | clear;

  edge_pulse u_edge (
    .clk   (clk),
    .rst   (srst),
    .sig   (enter),
    .pulse (press)
  );

  always_ff @(posedge clk) begin
    if (srst) state <= S_A;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_A:     if (press) state_nx = S_B;
      S_B:     if (press) state_nx = S_OP;
      S_OP:    if (press) state_nx = S_EXEC;
      S_EXEC:  if (cnt == 4'd0) state_nx = S_SHOW;
      S_SHOW:  if (press) state_nx = S_A;
      default: state_nx = S_A;
    endcase
  end

  always_comb begin
    ld_a     = (state == S_A)    & press;
    ld_b     = (state == S_B)    & press;
    ld_sel   = (state == S_OP)   & press;
    cnt_dec  = (state == S_EXEC) & (cnt != 4'd0);
    capture  = (state == S_EXEC) & (cnt == 4'd0);
    done_clr = (state == S_SHOW) & press;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      cnt     <= 4'd0;
      result  <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (ld_a)   alu_a   <= data_in;
      if (ld_b)   alu_b   <= data_in;
      if (ld_sel) alu_sel <= op_in;
      if (ld_sel)       cnt <= EXEC_WAIT_C;
      else if (cnt_dec) cnt <= cnt - 4'd1;
      if (capture) begin
        result <= alu_s;
        carry  <= alu_cout;
        done   <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_ula_operand_seq.sv
module tb_ula_operand_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic [2:0] op_in;
  logic       enter;
  logic       clear;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [4:0] alu_s;
  logic       alu_cout;
  logic [4:0] result;
  logic       carry;
  logic       done;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula_operand_seq #(.WIDTH(4), .SEL_W(3), .EXEC_WAIT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .op_in    (op_in),
    .enter    (enter),
    .clear    (clear),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_s    (alu_s),
    .alu_cout (alu_cout),
    .result   (result),
    .carry    (carry),
    .done     (done),
    .state_o  (state_o)
  );

  // Behavioural ALU: 5-bit operation result, low 4 bits on S, bit 4 on cout.
  logic [4:0] alu_full;
  always_comb begin
    alu_full = 5'd0;
    case (alu_sel)
      3'b000:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_full = {1'b0, alu_b >> 1};
      3'b011:  alu_full = {alu_b, 1'b0};
      default: alu_full = 5'd0;
    endcase
    alu_s    = {1'b0, alu_full[3:0]};
    alu_cout = alu_full[4];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press: enter high across one edge, then low across the next.
  task automatic press_btn();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  // Loads A, B, op; returns one edge after the op press edge (still in S_EXEC).
  task automatic load_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    data_in = a;
    press_btn();
    data_in = b;
    press_btn();
    op_in = op;
    press_btn();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; enter = 1'b0; data_in = 4'd0; op_in = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 5 + 3
    load_op(4'd5, 4'd3, 3'b000);
    chk("add_alu_a", 32'(alu_a), 32'd5);
    chk("add_alu_b", 32'(alu_b), 32'd3);
    chk("add_alu_sel", 32'(alu_sel), 32'd0);
    chk("exec_state", 32'(state_o), 32'd3);
    chk("exec_not_done", 32'(done), 32'd0);
    tick();
    chk("add_done", 32'(done), 32'd1);
    chk("add_result", 32'(result), 32'h08);
    chk("add_carry", 32'(carry), 32'd0);
    chk("add_show", 32'(state_o), 32'd4);
    tick();
    chk("show_hold", 32'(state_o), 32'd4);
    press_btn();
    chk("show_to_a", 32'(state_o), 32'd0);
    chk("show_done_clr", 32'(done), 32'd0);

    // 9 + 9 with carry
    load_op(4'd9, 4'd9, 3'b000);
    tick();
    chk("carry_result", 32'(result), 32'h02);
    chk("carry_carry", 32'(carry), 32'd1);
    press_btn();
    chk("carry_to_a", 32'(state_o), 32'd0);
    chk("carry_hold", 32'(result), 32'h02);

    // Held button: one advance only, operand loaded once
    data_in = 4'd7;
    enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) data_in = 4'd2;
    end
    chk("held_state", 32'(state_o), 32'd1);
    chk("held_alu_a", 32'(alu_a), 32'd7);
    enter = 1'b0;
    tick();
    chk("held_release", 32'(state_o), 32'd1);

    // Shift left of B = 1001
    data_in = 4'b1001;
    press_btn();
    op_in = 3'b011;
    press_btn();
    tick();
    chk("shl_result", 32'(result), 32'h02);
    chk("shl_carry", 32'(carry), 32'd1);
    press_btn();

    // Shift right of B = 1001
    load_op(4'd1, 4'b1001, 3'b010);
    tick();
    chk("shr_result", 32'(result), 32'h04);
    chk("shr_carry", 32'(carry), 32'd0);
    press_btn();

    // Subtract 3 - 5 borrows
    load_op(4'd3, 4'd5, 3'b001);
    tick();
    chk("sub_result", 32'(result), 32'h0E);
    chk("sub_carry", 32'(carry), 32'd1);
    press_btn();

    // Clear with a press while in S_EXEC aborts the capture
    load_op(4'd5, 4'd3, 3'b000);
    chk("abort_pre_state", 32'(state_o), 32'd3);
    clear = 1'b1;
    enter = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    tick();
    tick();
    chk("abort_no_capture", 32'(done), 32'd0);
    chk("abort_stays_a", 32'(state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
